// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory port: size encodings, latency
// bound and the response-entry layout used by the responder queue.
package cpu_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam int MAX_LATENCY = 8;

    typedef struct packed {
        logic [31:0] rdata;
        logic [2:0]  cnt;
    } resp_entry_t;

    // Size 3 falls into the default branch and is checked as a word.
    function automatic logic store_misaligned(input logic [1:0] size,
                                              input logic [1:0] lsb);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return lsb[0];
            default: return lsb != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// Data-SRAM-like request/response bus between the MEM stage (master) and
// the data memory (slave).
interface data_sram_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/data_sram_responder_resp_queue.sv
// In-order response FIFO; every entry counts down its own latency and the
// head is ready once its counter reaches zero.
module resp_queue
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int LATENCY = 2,
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [31:0]      push_rdata,
    input  logic             pop,
    output logic             head_ready,
    output logic [31:0]      head_rdata,
    output logic [CNT_W-1:0] count
);

    resp_entry_t      entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Stale entries keep counting down harmlessly; push reloads them.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && wr_ptr == PTR_W'(i)) begin
                entries[i].rdata <= push_rdata;
                entries[i].cnt   <= 3'(LATENCY - 1);
            end else if (entries[i].cnt != 3'd0) begin
                entries[i].cnt <= entries[i].cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_ready = (count != '0) && (entries[rd_ptr].cnt == 3'd0);
    assign head_rdata = entries[rd_ptr].rdata;

endmodule

// File: rtl/data_sram_responder.sv
// Word-addressed data memory behind the data-SRAM-like port: byte-strobed
// stores, sampled loads, fixed-latency in-order responses.
module data_sram_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH      = 10,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    data_sram_responder_if.slave bus,
    output logic                 misalign_err
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic                  accept;
    logic                  misal;
    logic                  store_ok;
    logic [31:0]           push_rdata;
    logic                  pop;
    logic                  head_ready;
    logic [31:0]           head_rdata;
    logic [31:0]           rdata_hold;
    logic [CNT_W-1:0]      count;
    logic                  unused_addr_bits;

    assign idx              = bus.addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^bus.addr[31:ADDR_WIDTH+2];

    // Full blocks acceptance even when the head retires this cycle.
    assign bus.addr_ok = resetn && bus.req && (count < CNT_W'(MAX_OUTSTANDING));
    assign accept      = bus.addr_ok;
    assign misal       = store_misaligned(bus.size, bus.addr[1:0]);
    assign store_ok    = accept && bus.wr && !misal;
    assign push_rdata  = bus.wr ? 32'h0 : mem[idx];

    always_ff @(posedge clk) begin
        if (store_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wstrb[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    resp_queue #(
        .DEPTH   (MAX_OUTSTANDING),
        .LATENCY (LATENCY)
    ) u_resp_queue (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept),
        .push_rdata (push_rdata),
        .pop        (pop),
        .head_ready (head_ready),
        .head_rdata (head_rdata),
        .count      (count)
    );

    // Response stage: an entry pending while reset is held is dropped.
    assign pop         = resetn && head_ready;
    assign bus.data_ok = pop;
    assign bus.rdata   = pop ? head_rdata : rdata_hold;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_hold   <= 32'h0;
            misalign_err <= 1'b0;
        end else begin
            if (pop) rdata_hold <= head_rdata;
            if (accept && bus.wr && misal) misalign_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed plus randomized bench for data_sram_responder, checked each cycle
// against a queue-based reference model of the memory and its responses.
module tb_data_sram_responder;

    localparam int AW   = 10;
    localparam int LAT  = 2;
    localparam int MAXO = 2;

    logic clk = 1'b0;
    logic resetn;
    logic misalign_err;

    always #5 clk = ~clk;

    data_sram_responder_if bus();

    data_sram_responder #(
        .ADDR_WIDTH      (AW),
        .LATENCY         (LAT),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus),
        .misalign_err (misalign_err)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        mq[$];
    logic [31:0] mmem [1024];
    logic        m_misal;
    logic [31:0] m_last;
    int          cyc;
    logic        acc_last;
    logic [31:0] obs_q[$];
    int          vectors;
    int          miscompares;
    logic [3:0]  pat;

    function automatic logic model_misal(input logic [1:0] s, input logic [31:0] a);
        return (s == 2'd1 && a[0]) || (s >= 2'd2 && a[1:0] != 2'b00);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic tick();
        logic        exp_ok, exp_dok, c_wr;
        logic [31:0] exp_r, c_addr, c_wdata;
        logic [1:0]  c_size;
        logic [3:0]  c_strb;
        int          w;
        exp_t        e;
        @(negedge clk);
        exp_ok  = resetn && bus.req && (mq.size() < MAXO);
        exp_dok = 1'b0;
        if (resetn && mq.size() > 0) exp_dok = (mq[0].due == cyc);
        exp_r   = exp_dok ? mq[0].data : m_last;
        chk("addr_ok", 32'(bus.addr_ok), 32'(exp_ok));
        chk("data_ok", 32'(bus.data_ok), 32'(exp_dok));
        chk("rdata", bus.rdata, exp_r);
        chk("misalign_err", 32'(misalign_err), 32'(m_misal));
        if (bus.data_ok === 1'b1) obs_q.push_back(bus.rdata);
        c_wr = bus.wr; c_size = bus.size; c_addr = bus.addr;
        c_strb = bus.wstrb; c_wdata = bus.wdata;
        @(posedge clk);
        if (!resetn) begin
            mq.delete();
            m_misal = 1'b0;
            m_last  = 32'h0;
        end else begin
            if (exp_dok) begin
                m_last = mq[0].data;
                void'(mq.pop_front());
            end
            if (exp_ok) begin
                w     = int'((c_addr >> 2) & 32'h3FF);
                e.due = cyc + LAT;
                if (c_wr) begin
                    if (model_misal(c_size, c_addr)) m_misal = 1'b1;
                    else
                        for (int b = 0; b < 4; b++)
                            if (c_strb[b]) mmem[w][8*b +: 8] = c_wdata[8*b +: 8];
                    e.data = 32'h0;
                end else begin
                    e.data = mmem[w];
                end
                mq.push_back(e);
            end
        end
        cyc++;
        acc_last = exp_ok;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue(input logic w, input logic [1:0] s, input logic [31:0] a,
                         input logic [3:0] st, input logic [31:0] d);
        bus.req = 1'b1; bus.wr = w; bus.size = s; bus.addr = a;
        bus.wstrb = st; bus.wdata = d;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (acc_last) break;
        end
        chk("accept_within_bound", 32'(acc_last), 32'd1);
        bus.req = 1'b0;
    endtask

    task automatic wait_resps(input int n);
        for (int i = 0; i < 40 && obs_q.size() < n; i++) tick();
        chk("response_count", 32'(obs_q.size()), 32'(n));
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; acc_last = 1'b0;
        m_misal = 1'b0; m_last = 32'h0;
        resetn = 1'b0;
        bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'd0; bus.addr = 32'h0;
        bus.wstrb = 4'h0; bus.wdata = 32'h0;
        @(posedge clk);
        #1;

        // reset state: addr_ok forced low even with req high
        bus.req = 1'b1;
        idle(2);
        bus.req = 1'b0;
        resetn = 1'b1;
        idle(1);

        for (int i = 0; i < 16; i++)
            issue(1'b1, 2'd2, 32'(i * 4), 4'hF, 32'hA000_0000 | 32'(i));
        idle(4);
        obs_q.delete();

        // store then load
        issue(1'b1, 2'd2, 32'h10, 4'hF, 32'hDEAD_BEEF);
        issue(1'b0, 2'd2, 32'h10, 4'h0, 32'h0);
        wait_resps(2);
        chk("t1_store_rdata", obs_q[0], 32'h0);
        chk("t1_load_rdata", obs_q[1], 32'hDEAD_BEEF);
        idle(2); obs_q.delete();

        // byte strobe
        issue(1'b1, 2'd2, 32'h20, 4'hF, 32'h1122_3344);
        issue(1'b1, 2'd0, 32'h22, 4'h4, 32'h00AA_0000);
        issue(1'b0, 2'd2, 32'h20, 4'h0, 32'h0);
        wait_resps(3);
        chk("t2_strobe_rdata", obs_q[2], 32'h11AA_3344);
        idle(2); obs_q.delete();

        // full queue with req held; address advances after each accept
        bus.req = 1'b1; bus.wr = 1'b0; bus.size = 2'd2; bus.addr = 32'h10;
        for (int k = 0; k < 4; k++) begin
            tick();
            pat[k] = acc_last;
            if (acc_last) bus.addr = (bus.addr == 32'h10) ? 32'h20 : 32'h24;
        end
        bus.req = 1'b0;
        chk("t3_accept_pattern", 32'(pat), 32'(4'b1011));
        wait_resps(3);
        chk("t3_order0", obs_q[0], 32'hDEAD_BEEF);
        chk("t3_order1", obs_q[1], 32'h11AA_3344);
        chk("t3_order2", obs_q[2], 32'hA000_0009);
        idle(2); obs_q.delete();

        // misaligned store
        issue(1'b1, 2'd2, 32'h31, 4'hF, 32'hFFFF_FFFF);
        wait_resps(1);
        chk("t4_store_rdata", obs_q[0], 32'h0);
        tick();
        chk("t4_misalign_set", 32'(misalign_err), 32'd1);
        issue(1'b0, 2'd2, 32'h30, 4'h0, 32'h0);
        wait_resps(2);
        chk("t4_word_unchanged", obs_q[1], 32'hA000_000C);
        chk("t4_misalign_sticky", 32'(misalign_err), 32'd1);
        idle(2); obs_q.delete();

        // reset with two loads outstanding
        issue(1'b0, 2'd2, 32'h10, 4'h0, 32'h0);
        issue(1'b0, 2'd2, 32'h20, 4'h0, 32'h0);
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
        idle(6);
        chk("t5_no_response", 32'(obs_q.size()), 32'd0);
        chk("t5_misalign_cleared", 32'(misalign_err), 32'd0);
        issue(1'b0, 2'd2, 32'h10, 4'h0, 32'h0);
        wait_resps(1);
        chk("t5_array_kept", obs_q[0], 32'hDEAD_BEEF);
        idle(2); obs_q.delete();

        // aliasing through ignored upper address bits
        issue(1'b1, 2'd2, 32'h1000, 4'hF, 32'h5);
        issue(1'b0, 2'd2, 32'h0, 4'h0, 32'h0);
        wait_resps(2);
        chk("t6_alias_rdata", obs_q[1], 32'h5);
        idle(2); obs_q.delete();

        // randomized traffic over the prefilled words, requests held until taken
        for (int n = 0; n < 400; n++) begin
            if (!bus.req || acc_last) begin
                bus.req   = ($urandom_range(0, 9) < 7);
                bus.wr    = 1'($urandom_range(0, 1));
                bus.size  = 2'($urandom_range(0, 3));
                bus.addr  = ($urandom() & 32'hFFFF_F000) |
                            (32'($urandom_range(0, 15)) << 2) |
                            32'($urandom_range(0, 3));
                bus.wstrb = 4'($urandom_range(0, 15));
                bus.wdata = $urandom();
            end
            tick();
        end
        bus.req = 1'b0;
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Memory-side responder for the CPU data-SRAM-like port: accepts load/store requests, holds a word-addressed backing array, and returns load words after a fixed latency.
- Serves as the data-memory end of the interface consumed by the MEM stage.
- Returns full aligned 32-bit words; byte/halfword extraction and sign extension remain in the pipeline.
- Used as the data memory in simulation and FPGA builds.

Parameters:
- ADDR_WIDTH, 10, word-index bits; the array holds 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, cycles from request acceptance to data_ok; legal range 1..8.
- MAX_OUTSTANDING, 2, maximum accepted requests not yet answered; legal range 1..4.

Ports:
- clk  input  1  clock
- resetn  input  1  synchronous active-low reset
- req  input  1  request valid
- wr  input  1  1 = store, 0 = load
- size  input  2  0 = byte, 1 = half, 2 = word
- addr  input  32  byte address
- wstrb  input  4  byte write enables for stores
- wdata  input  32  store data, already lane-aligned
- addr_ok  output  1  request accepted this cycle
- data_ok  output  1  response valid, single-cycle pulse
- rdata  output  32  aligned load word; 0 for store responses
- misalign_err  output  1  sticky misaligned-store flag

Behaviour:
- Reset (resetn sampled low at a posedge):
  - Queue empties; all outstanding requests are discarded and never answered.
  - data_ok=0, rdata=0, misalign_err=0.
  - addr_ok is forced to 0 while resetn is low.
  - Array contents are not reset.
- Acceptance:
  - addr_ok = resetn && req && (outstanding < MAX_OUTSTANDING). This is combinational from req.
  - A request is accepted at a posedge where req && addr_ok.
  - The requester holds req/wr/size/addr/wstrb/wdata stable until accepted.
- Indexing: word index = addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses alias.
- Store accepted at edge N:
  - Bytes selected by wstrb are written at edge N.
  - A response entry with rdata=0 is enqueued.
- Misaligned store: size=1 with addr[0]=1, or size=2 with addr[1:0]!=0.
  - Still accepted and still answered.
  - Array is not written.
  - misalign_err is set and stays set until reset.
- size=3 is treated as word.
- Load accepted at edge N:
  - The array word is sampled at edge N, reflecting all stores accepted before N.
  - That word is enqueued. A later store to the same word does not alter the queued data.
- Response timing:
  - Each entry carries a down-counter loaded with LATENCY-1.
  - An entry accepted at edge N presents data_ok=1 and its rdata during the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after acceptance.
  - data_ok is high for exactly one cycle; rdata holds its value until the next response.
- Ordering: responses are strictly in acceptance order. Latency is fixed, so there is at most one data_ok per cycle.
- Back-to-back requests accepted on consecutive edges yield data_ok on consecutive cycles.
- Occupancy:
  - outstanding increments on accept and decrements on the data_ok cycle.
  - Simultaneous accept and retire leaves it unchanged.
  - At full, addr_ok=0 even if a response retires in the same cycle; the next cycle admits.
- Queue storage: circular buffer with wrap-around pointers, width clog2(MAX_OUTSTANDING).
  - Full and empty are distinguished by a count, not by pointer equality.

Decomposition:
- Shared package (cpu_mem_pkg):
  - SIZE_B/SIZE_H/SIZE_W encodings.
  - MAX_LATENCY constant.
  - Response-entry struct {rdata[31:0], cnt[2:0]}.
- One sub-module, resp_queue:
  - Parameterized FIFO of response entries with per-entry latency countdown.
  - Exposes push, head_ready (head counter == 0), pop, and count.
- Array, strobe write and misalign check stay in the top module.

Test Plan:
- Store, then load, LATENCY=2:
  - Store addr=0x10, wstrb=0xF, wdata=0xDEADBEEF, then load addr=0x10 next cycle.
  - Expected: data_ok 2 cycles after each accept; load rdata=0xDEADBEEF.
- Byte strobe:
  - Word 0x20 = 0x11223344; store wstrb=0x4, wdata=0x00AA0000 at addr 0x22, then load 0x20.
  - Expected: rdata=0x11AA3344.
- Full queue, MAX_OUTSTANDING=2, req held continuously:
  - Expected: exactly 2 accepts, then addr_ok=0 until the first data_ok cycle has passed.
  - Response order matches acceptance order.
- Misaligned store:
  - size=2, addr=0x31, wstrb=0xF.
  - Expected: accepted, data_ok pulses, word 0x30 unchanged, misalign_err=1 until reset.
- Reset mid-operation:
  - Assert resetn=0 with 2 loads outstanding.
  - Expected: no data_ok ever issued for them; after release, addr_ok follows req and array data is preserved.
- Aliasing, ADDR_WIDTH=10:
  - Store 0x5 to addr 0x1000, then load addr 0x0.
  - Expected: rdata=0x5.
